// File: rtl/mux2to1_pkg.sv
// mux2to1_pkg
// Shared definitions for the 2:1 mux slice.
//   mux_style_e   : selects which combinational form mux2to1_core builds
//   DEFAULT_WIDTH : default data width of the mux
package mux2to1_pkg;

   typedef enum logic [1:0] {
      STYLE_COND,
      STYLE_IF,
      STYLE_CASE
   } mux_style_e;

   localparam int DEFAULT_WIDTH = 1;

endpackage : mux2to1_pkg

// File: rtl/mux2to1_core.sv
// mux2to1_core
// One purely combinational 2:1 mux, built in the form chosen by STYLE.
// Ports:
//   sel : select, 0 -> in0, 1 -> in1
//   in0 : data input chosen when sel=0
//   in1 : data input chosen when sel=1
//   y   : mux output
// The three forms differ only in how an unknown sel resolves:
//   STYLE_COND : bitwise merge (equal bits pass, differing bits go X)
//   STYLE_IF   : in1 only on sel==1, otherwise in0
//   STYLE_CASE : in0 / in1 on 0 / 1, in0 in the default branch
module mux2to1_core
   import mux2to1_pkg::*;
#(
   parameter int         WIDTH = DEFAULT_WIDTH,
   parameter mux_style_e STYLE = STYLE_COND
) (
   input  logic             sel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] y
);

   if (STYLE == STYLE_COND) begin : g_cond
      assign y = sel ? in1 : in0;
   end else if (STYLE == STYLE_IF) begin : g_if
      always_comb begin
         if (sel == 1'b1) begin
            y = in1;
         end else begin
            y = in0;
         end
      end
   end else begin : g_case
      always_comb begin
         case (sel)
            1'b0:    y = in0;
            1'b1:    y = in1;
            default: y = in0;
         endcase
      end
   end

endmodule : mux2to1_core

// File: rtl/mux2to1.sv
// mux2to1
// 2:1 mux presented in three combinational forms, with a registered copy
// and a sticky flag that records any disagreement between the forms.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset (clears out_q and mismatch)
//   sel      : select, 0 -> in0, 1 -> in1
//   in0/in1  : data inputs
//   out_cond : conditional-operator form
//   out_if   : if/else form
//   out_case : case form
//   out_q    : out_case registered, one cycle latency
//   mismatch : sticky, set when the three forms disagree at an edge
module mux2to1
   import mux2to1_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic [WIDTH-1:0] out_cond,
   output logic [WIDTH-1:0] out_if,
   output logic [WIDTH-1:0] out_case,
   output logic [WIDTH-1:0] out_q,
   output logic             mismatch
);

   logic [WIDTH-1:0] y_cond;
   logic [WIDTH-1:0] y_if;
   logic [WIDTH-1:0] y_case;
   logic             differ;

   mux2to1_core #(.WIDTH(WIDTH), .STYLE(STYLE_COND)) u_cond (
      .sel (sel),
      .in0 (in0),
      .in1 (in1),
      .y   (y_cond)
   );

   mux2to1_core #(.WIDTH(WIDTH), .STYLE(STYLE_IF)) u_if (
      .sel (sel),
      .in0 (in0),
      .in1 (in1),
      .y   (y_if)
   );

   mux2to1_core #(.WIDTH(WIDTH), .STYLE(STYLE_CASE)) u_case (
      .sel (sel),
      .in0 (in0),
      .in1 (in1),
      .y   (y_case)
   );

   assign out_cond = y_cond;
   assign out_if   = y_if;
   assign out_case = y_case;

   // Any pair differing implies cond!=if or if!=case.
   assign differ = (y_cond != y_if) || (y_if != y_case);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q    <= '0;
         mismatch <= 1'b0;
      end else begin
         out_q <= y_case;
         // An unknown sel makes this condition unknown, so the flag holds;
         // the forms are expected to disagree on X and that is not an error.
         if ((sel == 1'b0) || (sel == 1'b1)) begin
            if (differ) begin
               mismatch <= 1'b1;
            end
         end
      end
   end

endmodule : mux2to1

// File: tb/tb_mux2to1.sv
// tb_mux2to1
// Directed bench for mux2to1 at WIDTH=1, 8 and 4.
module tb_mux2to1;

   logic       clk;
   logic       rst;

   logic       sel1;
   logic [0:0] a1, b1, c1_cond, c1_if, c1_case, q1;
   logic       mm1;

   logic       sel8;
   logic [7:0] a8, b8, c8_cond, c8_if, c8_case, q8;
   logic       mm8;

   logic       sel4;
   logic [3:0] a4, b4, c4_cond, c4_if, c4_case, q4;
   logic       mm4;

   int n_checks = 0;
   int n_errors = 0;

   mux2to1 #(.WIDTH(1)) dut_w1 (
      .clk(clk), .rst(rst), .sel(sel1), .in0(a1), .in1(b1),
      .out_cond(c1_cond), .out_if(c1_if), .out_case(c1_case),
      .out_q(q1), .mismatch(mm1)
   );

   mux2to1 #(.WIDTH(8)) dut_w8 (
      .clk(clk), .rst(rst), .sel(sel8), .in0(a8), .in1(b8),
      .out_cond(c8_cond), .out_if(c8_if), .out_case(c8_case),
      .out_q(q8), .mismatch(mm8)
   );

   mux2to1 #(.WIDTH(4)) dut_w4 (
      .clk(clk), .rst(rst), .sel(sel4), .in0(a4), .in1(b4),
      .out_cond(c4_cond), .out_if(c4_if), .out_case(c4_case),
      .out_q(q4), .mismatch(mm4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      rst = 1'b1;
      sel1 = 1'b0; a1 = 1'b1; b1 = 1'b0;
      sel8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      sel4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
      #3;
      n_checks++; if (q1 !== 1'b0) begin n_errors++; $display("FAIL reset_q1: got %b want 0", q1); end
      n_checks++; if (q8 !== 8'h00) begin n_errors++; $display("FAIL reset_q8: got %h want 00", q8); end
      n_checks++; if (q4 !== 4'h0) begin n_errors++; $display("FAIL reset_q4: got %h want 0", q4); end
      n_checks++; if ({mm1, mm8, mm4} !== 3'b000) begin n_errors++; $display("FAIL reset_mismatch: got %b want 000", {mm1, mm8, mm4}); end
      // combinational path is live during reset
      n_checks++; if (c1_if !== 1'b1) begin n_errors++; $display("FAIL reset_comb_live: got %b want 1", c1_if); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_width1_combos();
      // combo index i = {sel, in1, in0}
      logic [7:0] exp_tbl;
      logic [2:0] v;
      exp_tbl = 8'b1100_1010;   // bit i: 0,1,0,1,0,0,1,1
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         sel1 = v[2]; b1 = v[1]; a1 = v[0];
         #1;
         n_checks++; if (c1_cond !== exp_tbl[i]) begin n_errors++; $display("FAIL combo%0d_cond: got %b want %b", i, c1_cond, exp_tbl[i]); end
         n_checks++; if (c1_if !== exp_tbl[i]) begin n_errors++; $display("FAIL combo%0d_if: got %b want %b", i, c1_if, exp_tbl[i]); end
         n_checks++; if (c1_case !== exp_tbl[i]) begin n_errors++; $display("FAIL combo%0d_case: got %b want %b", i, c1_case, exp_tbl[i]); end
         #49;
      end
      n_checks++; if (mm1 !== 1'b0) begin n_errors++; $display("FAIL combo_mismatch: got %b want 0", mm1); end
   endtask

   task automatic test_width8();
      @(negedge clk);
      sel8 = 1'b0; a8 = 8'hA5; b8 = 8'h3C;
      #1;
      n_checks++; if (c8_cond !== 8'hA5) begin n_errors++; $display("FAIL w8_sel0_cond: got %h want a5", c8_cond); end
      n_checks++; if (c8_if !== 8'hA5) begin n_errors++; $display("FAIL w8_sel0_if: got %h want a5", c8_if); end
      n_checks++; if (c8_case !== 8'hA5) begin n_errors++; $display("FAIL w8_sel0_case: got %h want a5", c8_case); end
      @(posedge clk); #1;
      n_checks++; if (q8 !== 8'hA5) begin n_errors++; $display("FAIL w8_sel0_q: got %h want a5", q8); end
      @(negedge clk);
      sel8 = 1'b1;
      #1;
      n_checks++; if (c8_cond !== 8'h3C) begin n_errors++; $display("FAIL w8_sel1_cond: got %h want 3c", c8_cond); end
      n_checks++; if (c8_if !== 8'h3C) begin n_errors++; $display("FAIL w8_sel1_if: got %h want 3c", c8_if); end
      n_checks++; if (c8_case !== 8'h3C) begin n_errors++; $display("FAIL w8_sel1_case: got %h want 3c", c8_case); end
      @(posedge clk); #1;
      n_checks++; if (q8 !== 8'h3C) begin n_errors++; $display("FAIL w8_sel1_q: got %h want 3c", q8); end
      n_checks++; if (mm8 !== 1'b0) begin n_errors++; $display("FAIL w8_mismatch: got %b want 0", mm8); end
   endtask

   task automatic test_latency();
      @(negedge clk);
      sel1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (q1 !== 1'b0) begin n_errors++; $display("FAIL lat_init_q: got %b want 0", q1); end
      @(negedge clk);
      b1 = 1'b1;
      #1;
      n_checks++; if (c1_case !== 1'b1) begin n_errors++; $display("FAIL lat_comb: got %b want 1", c1_case); end
      n_checks++; if (q1 !== 1'b0) begin n_errors++; $display("FAIL lat_before_edge: got %b want 0", q1); end
      @(posedge clk); #1;
      n_checks++; if (q1 !== 1'b1) begin n_errors++; $display("FAIL lat_after_edge: got %b want 1", q1); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      n_checks++; if (q1 !== 1'b1) begin n_errors++; $display("FAIL arst_pre_q: got %b want 1", q1); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (q1 !== 1'b0) begin n_errors++; $display("FAIL arst_q: got %b want 0", q1); end
      n_checks++; if (q8 !== 8'h00) begin n_errors++; $display("FAIL arst_q8: got %h want 00", q8); end
      n_checks++; if (mm1 !== 1'b0) begin n_errors++; $display("FAIL arst_mismatch: got %b want 0", mm1); end
      n_checks++; if ({c1_cond, c1_if, c1_case} !== 3'b111) begin n_errors++; $display("FAIL arst_comb: got %b want 111", {c1_cond, c1_if, c1_case}); end
      n_checks++; if (c8_case !== 8'h3C) begin n_errors++; $display("FAIL arst_comb8: got %h want 3c", c8_case); end
      @(posedge clk); #1;
      n_checks++; if (q1 !== 1'b0) begin n_errors++; $display("FAIL arst_hold_q: got %b want 0", q1); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (q1 !== 1'b1) begin n_errors++; $display("FAIL arst_first_edge_q: got %b want 1", q1); end
   endtask

   task automatic test_sel_unknown();
      logic exp_cond;
      logic exp_ifcase;
      @(negedge clk);
      sel1 = 1'bx; a1 = 1'b1; b1 = 1'b1;
      #1;
      n_checks++; if (c1_cond !== 1'b1) begin n_errors++; $display("FAIL selx_eq_cond: got %b want 1", c1_cond); end
      n_checks++; if (c1_if !== 1'b1) begin n_errors++; $display("FAIL selx_eq_if: got %b want 1", c1_if); end
      n_checks++; if (c1_case !== 1'b1) begin n_errors++; $display("FAIL selx_eq_case: got %b want 1", c1_case); end
      a1 = 1'b0;
      // A 2-state simulator resolves the X drive to a known select.
      if ($isunknown(sel1)) begin
         exp_cond   = 1'bx;
         exp_ifcase = 1'b0;
      end else begin
         exp_cond   = sel1 ? 1'b1 : 1'b0;
         exp_ifcase = exp_cond;
      end
      #1;
      n_checks++; if (c1_cond !== exp_cond) begin n_errors++; $display("FAIL selx_diff_cond: got %b want %b", c1_cond, exp_cond); end
      n_checks++; if (c1_if !== exp_ifcase) begin n_errors++; $display("FAIL selx_diff_if: got %b want %b", c1_if, exp_ifcase); end
      n_checks++; if (c1_case !== exp_ifcase) begin n_errors++; $display("FAIL selx_diff_case: got %b want %b", c1_case, exp_ifcase); end
      @(posedge clk); #1;
      n_checks++; if (mm1 !== 1'b0) begin n_errors++; $display("FAIL selx_mismatch: got %b want 0", mm1); end
      @(negedge clk);
      sel1 = 1'b0;
   endtask

   task automatic test_sticky();
      @(negedge clk);
      sel8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      force dut_w8.y_if = 8'hFF;
      @(posedge clk); #1;
      n_checks++; if (mm8 !== 1'b1) begin n_errors++; $display("FAIL sticky_set: got %b want 1", mm8); end
      @(negedge clk);
      release dut_w8.y_if;
      @(posedge clk); #1;
      n_checks++; if (mm8 !== 1'b1) begin n_errors++; $display("FAIL sticky_hold: got %b want 1", mm8); end
      n_checks++; if (c8_if !== 8'h00) begin n_errors++; $display("FAIL sticky_released: got %h want 00", c8_if); end
      n_checks++; if ({mm1, mm4} !== 2'b00) begin n_errors++; $display("FAIL sticky_others: got %b want 00", {mm1, mm4}); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++; if (mm8 !== 1'b0) begin n_errors++; $display("FAIL sticky_clear: got %b want 0", mm8); end
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (mm8 !== 1'b0) begin n_errors++; $display("FAIL sticky_after_clear: got %b want 0", mm8); end
   endtask

   task automatic test_random();
      logic [3:0] exp;
      int         errs_before;
      errs_before = n_errors;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         sel4 = 1'($urandom_range(1, 0));
         a4   = 4'($urandom_range(15, 0));
         b4   = 4'($urandom_range(15, 0));
         exp  = (sel4 == 1'b1) ? b4 : a4;
         #1;
         n_checks++; if (c4_case !== exp) begin n_errors++; if (n_errors - errs_before < 10) $display("FAIL rand_comb[%0d]: got %h want %h", i, c4_case, exp); end
         @(posedge clk); #1;
         n_checks++; if (q4 !== exp) begin n_errors++; if (n_errors - errs_before < 10) $display("FAIL rand_q[%0d]: got %h want %h", i, q4, exp); end
         n_checks++; if (mm4 !== 1'b0) begin n_errors++; if (n_errors - errs_before < 10) $display("FAIL rand_mismatch[%0d]: got %b want 0", i, mm4); end
      end
   endtask

   initial begin
      test_reset();
      test_width1_combos();
      test_width8();
      test_latency();
      test_async_reset();
      test_sel_unknown();
      test_sticky();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_mux2to1
